spi_link_receiver: RTL and testbench
====================================

# spi_link_receiver

Serial-to-parallel front end for one network link of a node. It synchronises the neighbour's master-SPI lines (clock, check/CS, data), deserialises 32-bit instruction frames MSB-first, and buffers complete words in a small FIFO. It presents them to the node's receiver queue as a data word plus an active-high check line. Each node instantiates one receiver per input direction (left, right, self).

## Interface

Parameters:
- WIDTH, 32, frame/word length in bits
- DEPTH, 4, FIFO entries (power of two, ≥2)
- SYNC_STAGES, 2, flops per input synchroniser (≥2)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- spi_clk  in  1  neighbour serial clock, asynchronous to clk
- spi_cs  in  1  neighbour check line; high = frame active
- spi_data  in  1  serial data, MSB first
- out_data  out  WIDTH  head-of-FIFO word; reset 0
- out_check  out  1  high while FIFO non-empty; reset 0
- out_ack  in  1  pop head when out_check high; ignored otherwise
- frame_err  out  1  one-cycle pulse on malformed frame; reset 0
- overflow  out  1  one-cycle pulse on word dropped (FIFO full); reset 0
- drop_count  out  8  saturating count of dropped and malformed frames; reset 0

## Operation

- Inputs pass through SYNC_STAGES-flop synchronisers. Edge detection uses the synchronised values plus one delay flop.
- Data is sampled on the synchronised rising edge of spi_clk only while synchronised spi_cs is high. Bits shift in from the LSB end; the first bit ends up at bit WIDTH-1.
- FSM states:
  - WAIT_IDLE (reset state): wait for cs low, then go to IDLE. A frame already in progress at reset is never captured.
  - IDLE: on cs rise, clear bit counter and bad flag, go to SHIFT.
  - SHIFT: count sampled bits. On the WIDTH-th bit, go to FULL.
  - FULL: any further sampled bit sets the bad flag.
- Leaving SHIFT or FULL on cs fall:
  - From FULL with bad flag clear: push the word and go to IDLE.
  - From SHIFT (short frame), or from FULL with bad flag set (long frame): discard, pulse frame_err, increment drop_count, go to IDLE.
  - cs rise and fall with zero bits: a short frame, reported as error.
- Push when FIFO full and no pop in the same cycle: word dropped, overflow pulse, drop_count increment.
- Push and pop in the same cycle when full: both happen and nothing is dropped.
- Push and pop in the same cycle when empty: not possible; a pop requires out_check high.
- drop_count saturates at 255. It increments by at most 1 per cycle; error and overflow cannot coincide, since a frame is either pushed or rejected.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. An occupancy counter of log2(DEPTH)+1 bits distinguishes full from empty.
- out_data is valid only while out_check is high. When the FIFO is empty, out_data holds the last popped value.
- Reset clears the FIFO, pointers, counters, FSM and synchronisers in one cycle.

## Timing

- Raw-to-synchronised latency is SYNC_STAGES cycles. Edge detect adds 1 cycle.
- spi_clk high and low phases must each be ≥ SYNC_STAGES+1 clk cycles.
- spi_data must be stable from one spi_clk high phase before to one after the rising edge.
- spi_cs fall must follow the last spi_clk rise by ≥ SYNC_STAGES+1 cycles.
- Let T be the cycle in which the synchronised cs fall is detected. The push occurs at T. If the FIFO was empty, out_check is high and out_data is valid from T+1.
- out_ack sampled high at cycle P pops the head. The new head, or out_check low, appears at P+1.
- frame_err and overflow pulse at T+1 for exactly one cycle.
- Throughput: one frame per cs frame; back-to-back frames need a cs low time ≥ SYNC_STAGES+1 cycles.

## Structure

- Shared package `link_pkg`: WIDTH default, FSM state encoding (WAIT_IDLE, IDLE, SHIFT, FULL), drop-counter width.
- One sub-module: `link_fifo`, a synchronous single-clock FIFO (DEPTH, WIDTH; push/pop/full/empty/head). It is reused later by the transmit side.
- Synchronisers and the deserialiser/FSM stay in spi_link_receiver.

## Test plan

- Reset, then one 32-bit frame 0xDEADBEEF with out_ack low -> out_check high at T+1, out_data=0xDEADBEEF; out_ack one cycle -> out_check low next cycle.
- Five back-to-back frames 1..5 with DEPTH=4 and no ack -> frames 1-4 held; overflow pulse on frame 5; drop_count=1; acks return 1,2,3,4 in order.
- Frame with 31 bits, then frame with 33 bits -> two frame_err pulses, no push, drop_count=2; next valid frame 0x00000001 delivered normally.
- FIFO full, final cs fall coincident with out_ack -> no overflow; occupancy stays 4; new word at the tail.
- Assert reset for 1 cycle after 16 bits of a frame, with cs still high -> remaining bits ignored, no push, no frame_err; next full frame 0xA5A5A5A5 delivered.
- 260 malformed frames -> drop_count saturates at 255 and stays there.

Source files
------------

// File: rtl/link_pkg.sv
// Shared definitions for the link receive/transmit path: word width,
// deserialiser state encoding and drop-counter width.
package link_pkg;

    localparam int unsigned LINK_WIDTH = 32;
    localparam int unsigned DROP_W     = 8;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        FULL      = 2'd3
    } rxState_e;

endpackage

// File: rtl/spi_link_receiver_if.sv
// Word handshake between a link receiver (master) and the node's receiver queue (slave).
interface spi_link_receiver_if #(
    parameter int unsigned WIDTH = 32
);

    logic [WIDTH-1:0] out_data;
    logic             out_check;
    logic             out_ack;

    modport master (output out_data, output out_check, input out_ack);
    modport slave  (input out_data, input out_check, output out_ack);

endinterface

// File: rtl/link_fifo.sv
// Single-clock FIFO with a registered head that holds the last popped word
// while empty.
module link_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] rdNext;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   countNext;
    logic             doPush;
    logic             doPop;

    assign empty  = (count == '0);
    assign full   = (count == (PTR_W + 1)'(DEPTH));
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);
    assign rdNext = doPop ? rdPtr + PTR_W'(1) : rdPtr;

    always_comb begin
        countNext = count;
        case ({doPush, doPop})
            2'b10:   countNext = count + 1'b1;
            2'b01:   countNext = count - 1'b1;
            default: countNext = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Head is registered; a word written into the slot becoming head bypasses memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            head  <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            rdPtr <= rdNext;
            count <= countNext;
            if (countNext != '0) begin
                head <= (doPush && (wrPtr == rdNext)) ? pushData : mem[rdNext];
            end
        end
    end

endmodule

// File: rtl/spi_link_receiver.sv
// Link receive front end: synchronises neighbour SPI lines, deserialises
// MSB-first frames and queues complete words for the node.
module spi_link_receiver
    import link_pkg::*;
#(
    parameter int unsigned WIDTH       = LINK_WIDTH,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                spi_clk,
    input  logic                spi_cs,
    input  logic                spi_data,
    spi_link_receiver_if.master link,
    output logic                frame_err,
    output logic                overflow,
    output logic [DROP_W-1:0]   drop_count
);

    localparam int unsigned CNT_W    = $clog2(WIDTH + 1);
    localparam int unsigned SETTLE   = SYNC_STAGES + 1;
    localparam int unsigned SETTLE_W = $clog2(SETTLE + 1);

    logic [SYNC_STAGES-1:0] clkSync;
    logic [SYNC_STAGES-1:0] csSync;
    logic [SYNC_STAGES-1:0] dataSync;
    logic                   clkDly;
    logic                   csDly;
    logic [SETTLE_W-1:0]    settleCnt;

    logic sclkS, csS, dataS, sclkRise, csRise, csFall, settled;

    rxState_e         state, stateNext;
    logic [WIDTH-1:0] shiftReg, shiftNext;
    logic [CNT_W-1:0] bitCnt, cntNext;
    logic             bad, badNext;
    logic             pushReq, errReq;

    logic fifoFull, fifoEmpty, popReq, ovfNow;

    assign sclkS    = clkSync[SYNC_STAGES-1];
    assign csS      = csSync[SYNC_STAGES-1];
    assign dataS    = dataSync[SYNC_STAGES-1];
    assign sclkRise = sclkS & ~clkDly;
    assign csRise   = csS & ~csDly;
    assign csFall   = ~csS & csDly;
    assign settled  = (settleCnt == SETTLE_W'(SETTLE));

    // The settle count keeps WAIT_IDLE from trusting the cleared synchronisers,
    // so a frame already active at reset is not mistaken for idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            clkSync   <= '0;
            csSync    <= '0;
            dataSync  <= '0;
            clkDly    <= 1'b0;
            csDly     <= 1'b0;
            settleCnt <= '0;
        end else begin
            clkSync  <= {clkSync[SYNC_STAGES-2:0], spi_clk};
            csSync   <= {csSync[SYNC_STAGES-2:0], spi_cs};
            dataSync <= {dataSync[SYNC_STAGES-2:0], spi_data};
            clkDly   <= sclkS;
            csDly    <= csS;
            if (!settled) begin
                settleCnt <= settleCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= WAIT_IDLE;
            shiftReg <= '0;
            bitCnt   <= '0;
            bad      <= 1'b0;
        end else begin
            state    <= stateNext;
            shiftReg <= shiftNext;
            bitCnt   <= cntNext;
            bad      <= badNext;
        end
    end

    always_comb begin
        stateNext = state;
        shiftNext = shiftReg;
        cntNext   = bitCnt;
        badNext   = bad;
        pushReq   = 1'b0;
        errReq    = 1'b0;
        case (state)
            WAIT_IDLE: begin
                if (settled && !csS) stateNext = IDLE;
            end
            IDLE: begin
                if (csRise) begin
                    stateNext = SHIFT;
                    cntNext   = '0;
                    badNext   = 1'b0;
                end
            end
            SHIFT: begin
                if (csFall) begin
                    errReq    = 1'b1;
                    stateNext = IDLE;
                end else if (sclkRise) begin
                    shiftNext = {shiftReg[WIDTH-2:0], dataS};
                    cntNext   = bitCnt + 1'b1;
                    if (bitCnt == CNT_W'(WIDTH - 1)) stateNext = FULL;
                end
            end
            FULL: begin
                if (csFall) begin
                    pushReq   = ~bad;
                    errReq    = bad;
                    stateNext = IDLE;
                end else if (sclkRise) begin
                    badNext = 1'b1;
                end
            end
            default: stateNext = WAIT_IDLE;
        endcase
    end

    assign popReq = link.out_ack & ~fifoEmpty;
    assign ovfNow = pushReq & fifoFull & ~popReq;

    link_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (pushReq),
        .pushData (shiftReg),
        .pop      (popReq),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .head     (link.out_data)
    );

    assign link.out_check = ~fifoEmpty;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            frame_err <= errReq;
            overflow  <= ovfNow;
            if ((errReq || ovfNow) && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_link_receiver.sv
// Directed bench for spi_link_receiver: a queue-based model of the FIFO and
// drop accounting, checked every cycle, plus literal checkpoints.
`timescale 1ns/1ps
module tb_spi_link_receiver;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SYNC  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_clk, spi_cs, spi_data;
    logic       frame_err, overflow;
    logic [7:0] drop_count;

    spi_link_receiver_if #(.WIDTH(32)) lnk ();

    spi_link_receiver #(
        .WIDTH       (32),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .spi_clk    (spi_clk),
        .spi_cs     (spi_cs),
        .spi_data   (spi_data),
        .link       (lnk.master),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned at;
        bit          valid;
        logic [31:0] word;
    } ev_t;

    ev_t         evQ[$];
    logic [31:0] q[$];
    logic [31:0] lastPop = '0;
    int unsigned expDrop = 0;
    bit          expErr = 0, expOvf = 0, modelOn = 0;
    int unsigned edgeCnt = 0;
    int unsigned nAsserts = 0, nFails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nAsserts++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a completed frame takes effect SYNC+1 edges after the raw cs fall.
    always @(posedge clk) begin
        bit          popNow, wasFull;
        ev_t         e;
        edgeCnt++;
        if (reset) begin
            q.delete();
            lastPop = '0;
            expDrop = 0;
            expErr  = 0;
            expOvf  = 0;
            modelOn = 1;
        end else begin
            expErr  = 0;
            expOvf  = 0;
            popNow  = lnk.out_ack && (q.size() > 0);
            wasFull = (q.size() == DEPTH);
            if (popNow) lastPop = q.pop_front();
            if (evQ.size() > 0 && evQ[0].at == edgeCnt) begin
                e = evQ.pop_front();
                if (!e.valid) begin
                    expErr = 1;
                    if (expDrop < 255) expDrop++;
                end else if (wasFull && !popNow) begin
                    expOvf = 1;
                    if (expDrop < 255) expDrop++;
                end else begin
                    q.push_back(e.word);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (modelOn) begin
            check("out_check", lnk.out_check, (q.size() > 0));
            check("out_data", lnk.out_data, (q.size() > 0) ? q[0] : lastPop);
            check("frame_err", frame_err, expErr);
            check("overflow", overflow, expOvf);
            check("drop_count", drop_count, expDrop);
        end
    end

    task automatic sendBit(input logic b);
        spi_data = b;
        repeat (4) @(negedge clk);
        spi_clk = 1'b1;
        repeat (4) @(negedge clk);
        spi_clk = 1'b0;
    endtask

    task automatic sendFrame(input logic [63:0] bits, input int unsigned n, input bit ackAtFall);
        ev_t e;
        @(negedge clk);
        spi_cs = 1'b1;
        repeat (4) @(negedge clk);
        for (int unsigned i = 0; i < n; i++) sendBit(bits[n-1-i]);
        repeat (4) @(negedge clk);
        spi_cs   = 1'b0;
        e.at     = edgeCnt + SYNC + 1;
        e.valid  = (n == 32);
        e.word   = bits[31:0];
        evQ.push_back(e);
        if (ackAtFall) begin
            repeat (2) @(negedge clk);
            lnk.out_ack = 1'b1;
            @(negedge clk);
            lnk.out_ack = 1'b0;
            repeat (4) @(negedge clk);
        end else begin
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic ackOne(input logic [31:0] exp);
        check("ack_head", lnk.out_data, exp);
        lnk.out_ack = 1'b1;
        @(negedge clk);
        lnk.out_ack = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; spi_clk = 1'b0; spi_cs = 1'b0; spi_data = 1'b0; lnk.out_ack = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_out_check", lnk.out_check, 0);
        check("rst_out_data", lnk.out_data, 0);
        check("rst_drop", drop_count, 0);

        // Single frame, then pop.
        sendFrame(64'hDEADBEEF, 32, 0);
        check("t1_check", lnk.out_check, 1);
        check("t1_data", lnk.out_data, 32'hDEADBEEF);
        ackOne(32'hDEADBEEF);
        check("t1_empty", lnk.out_check, 0);
        check("t1_hold", lnk.out_data, 32'hDEADBEEF);

        // Overflow on the fifth word.
        doReset();
        for (int unsigned k = 1; k <= 5; k++) sendFrame(64'(k), 32, 0);
        check("t2_drop", drop_count, 1);
        for (int unsigned k = 1; k <= 4; k++) ackOne(32'(k));
        check("t2_empty", lnk.out_check, 0);

        // Short and long frames rejected, then a good one.
        doReset();
        sendFrame(64'h7FFF_FFFF, 31, 0);
        sendFrame(64'h1_2345_6789, 33, 0);
        check("t3_drop", drop_count, 2);
        check("t3_empty", lnk.out_check, 0);
        sendFrame(64'h1, 32, 0);
        ackOne(32'h1);

        // Push coincident with pop on a full FIFO.
        doReset();
        for (int unsigned k = 1; k <= 4; k++) sendFrame(64'(k), 32, 0);
        sendFrame(64'h5, 32, 1);
        check("t4_drop", drop_count, 0);
        for (int unsigned k = 2; k <= 5; k++) ackOne(32'(k));
        check("t4_empty", lnk.out_check, 0);

        // Reset mid-frame with cs held high.
        doReset();
        sendFrame(64'h12345678, 32, 0);
        @(negedge clk);
        spi_cs = 1'b1;
        repeat (4) @(negedge clk);
        for (int unsigned i = 0; i < 16; i++) sendBit(1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int unsigned i = 0; i < 16; i++) sendBit(1'b0);
        repeat (4) @(negedge clk);
        spi_cs = 1'b0;
        repeat (8) @(negedge clk);
        check("t5_cleared", lnk.out_check, 0);
        check("t5_drop", drop_count, 0);
        sendFrame(64'hA5A5A5A5, 32, 0);
        ackOne(32'hA5A5A5A5);

        // Drop counter saturation.
        doReset();
        for (int unsigned k = 0; k < 260; k++) sendFrame(64'h0, 0, 0);
        check("t6_sat", drop_count, 255);
        sendFrame(64'h0, 0, 0);
        check("t6_sat_hold", drop_count, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
